wram_asic_port: RTL and testbench
=================================

// Module: wram_asic_port
// PURPOSE
// - Word-RAM responder for the graphics ASIC's read/write strobes (oe/we/addr/din) in 2M sub-owned mode.
// - Converts level strobes sampled on sub_sync into single req/ack memory transactions and returns registered read data.
// - Applies Mega-CD priority mode (PM) to ASIC writes by nibble-wise read-modify-write.
// - Sits between the ASIC and the shared word-RAM memory arbiter. Sub-CPU traffic has priority.
// PARAMETERS
// - SYNC_BUDGET   2   sub_sync ticks allowed per transaction before asic_miss is flagged
// PORTS
// - clk_asic       in   1   system clock
// - rst            in   1   synchronous reset, active-high
// - sub_sync       in   1   sub-CPU clock-enable tick; strobes are sampled only on it
// - asic_oe        in   1   ASIC read strobe, level
// - asic_we        in   1   ASIC write strobe, level; wins if asic_oe is also high
// - asic_addr      in   17  word address [17:1]
// - asic_din       in   16  ASIC write data
// - asic_dout      out  16  registered read data
// - pm             in   2   priority mode: 00 off, 01 underwrite, 10 overwrite, 11 = off
// - wram_mode      in   1   1 = 1M mode; the port is disabled
// - wram_for_sub   in   1   2M bank owned by sub side
// - sub_req        in   1   sub-CPU word-RAM access pending; higher priority
// - mem_req        out  1   memory request, held until mem_ack
// - mem_we         out  1   1 = write cycle
// - mem_addr       out  17  memory word address
// - mem_din        out  16  memory write data
// - mem_dout       in   16  memory read data, valid with mem_ack
// - mem_ack        in   1   one-cycle transaction-complete pulse
// - port_busy      out  1   transaction in flight
// - asic_miss      out  1   sticky; set on budget overrun; cleared by next accepted request
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, sig_valid 0, miss counter 0.
// - enable = !wram_mode & wram_for_sub.
// - Accept: on sub_sync in IDLE when enable & !sub_req & (asic_oe|asic_we),
//   and ({asic_we,asic_addr,asic_din} != last_sig or !sig_valid).
//   At accept, latch the signature and all request fields.
// - Duplicate suppression: a held strobe with an unchanged signature is served once. A write is never repeated.
// - Invalidate sig_valid: on a sub_sync with oe=we=0, on !enable, or on an aborted transaction.
// - FSM: IDLE -> RD -> MERGE -> WR -> IDLE.
//   - Read: IDLE -> RD -> IDLE.
//   - Write, pm off: IDLE -> WR -> IDLE.
//   - Write, pm on: IDLE -> RD -> MERGE -> WR -> IDLE.
// - RD/WR: mem_req=1 from the cycle after accept until the mem_ack cycle inclusive. mem_req drops the next cycle.
// - Read: asic_dout <= mem_dout on mem_ack. Latency is accept + 1 + memory latency.
// - MERGE: 1 cycle, no request. Per nibble n (old=mem_dout latched, new=asic_din):
//   - underwrite: out = old!=0 ? old : new.
//   - overwrite: out = new!=0 ? new : old.
// - Abort: if enable falls mid-transaction, any outstanding mem_req is held until mem_ack, because memory cycles cannot be cancelled.
//   - Read data is then discarded, no further phases run, FSM returns to IDLE, and sig_valid is cleared.
// - sub_req asserting mid-transaction does not preempt; it only blocks new accepts.
// - Budget: count sub_sync ticks while busy. At count == SYNC_BUDGET, set asic_miss. The transaction still completes.
// - Reset mid-operation: mem_req drops on the next edge. The memory side tolerates a dropped request.
// - port_busy = (state != IDLE).
// STRUCTURE
// - Package mcd_wram_pkg holds: state enum (IDLE, RD, MERGE, WR); PM_OFF/PM_UNDER/PM_OVER constants; the width of the 17-bit word-address type.
// - Sub-module pm_nibble_merge (combinational): inputs old[15:0], new[15:0], pm[1:0]; output merged[15:0].
// - Top level contains the FSM, signature register, budget counter and output registers.
// TESTING
// - Read: oe, addr=0x01000, mem_dout=0xBEEF, ack 3 clk later -> one mem_req; asic_dout=0xBEEF; no 2nd req while oe is held.
// - Write pm=00: we, addr=0x00040, din=0x1234 held 3 ticks -> exactly one write of 0x1234 at 0x00040.
// - Underwrite pm=01: old=0x0F00, din=0x1234 -> read then write 0x1F34.
// - Overwrite pm=10: old=0xABCD, din=0x0500 -> written 0xA5CD.
// - Abort: drop wram_for_sub during RD -> mem_req held until ack, no write phase, next identical req reissued.
// - Budget/sub_req: ack delayed 3 sub_sync -> asic_miss=1; sub_req=1 at strobe -> no accept until it drops.

Source files
------------

// File: rtl/mcd_wram_pkg.sv
// Shared types and constants for the Mega-CD word-RAM ASIC port.
// State encoding, priority-mode codes and the word-address type.
package mcd_wram_pkg;

    localparam int ADDR_W = 17;

    typedef logic [ADDR_W-1:0] waddr_t;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        MERGE,
        WR
    } state_t;

    localparam logic [1:0] PM_OFF   = 2'b00;
    localparam logic [1:0] PM_UNDER = 2'b01;
    localparam logic [1:0] PM_OVER  = 2'b10;

    // Code 11 behaves like off, so only the two real modes need a merge.
    function automatic logic pm_active(input logic [1:0] mode);
        return (mode != PM_OFF) && (mode != 2'b11);
    endfunction

endpackage

// File: rtl/wram_asic_port_if.sv
// ASIC strobe bus plus word-RAM memory handshake.
// master = the port itself, slave = ASIC and memory arbiter side.
interface wram_asic_port_if;
    import mcd_wram_pkg::*;

    logic        asic_oe;
    logic        asic_we;
    waddr_t      asic_addr;
    logic [15:0] asic_din;
    logic [15:0] asic_dout;

    logic        mem_req;
    logic        mem_we;
    waddr_t      mem_addr;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;
    logic        mem_ack;

    modport master (
        input  asic_oe, asic_we, asic_addr, asic_din,
        input  mem_dout, mem_ack,
        output asic_dout,
        output mem_req, mem_we, mem_addr, mem_din
    );

    modport slave (
        output asic_oe, asic_we, asic_addr, asic_din,
        output mem_dout, mem_ack,
        input  asic_dout,
        input  mem_req, mem_we, mem_addr, mem_din
    );

endinterface

// File: rtl/pm_nibble_merge.sv
// Priority-mode nibble merge of an ASIC write onto existing RAM data.
// Underwrite keeps non-zero old nibbles; overwrite keeps non-zero new ones.
module pm_nibble_merge
    import mcd_wram_pkg::*;
(
    input  logic [15:0] old_data,
    input  logic [15:0] new_data,
    input  logic [1:0]  pm,
    output logic [15:0] merged
);

    // Select each nibble independently according to the mode.
    always_comb begin
        merged = new_data;
        for (int n = 0; n < 4; n++) begin
            unique case (pm)
                PM_UNDER: merged[n*4 +: 4] = (old_data[n*4 +: 4] != 4'h0) ?
                                             old_data[n*4 +: 4] : new_data[n*4 +: 4];
                PM_OVER:  merged[n*4 +: 4] = (new_data[n*4 +: 4] != 4'h0) ?
                                             new_data[n*4 +: 4] : old_data[n*4 +: 4];
                default:  merged[n*4 +: 4] = new_data[n*4 +: 4];
            endcase
        end
    end

endmodule

// File: rtl/wram_asic_port.sv
// Word-RAM responder for the graphics ASIC in 2M sub-owned mode.
// Turns sampled level strobes into single req/ack memory transactions.
module wram_asic_port
    import mcd_wram_pkg::*;
#(
    parameter int SYNC_BUDGET = 2
) (
    input  logic             clk_asic,
    input  logic             rst,
    input  logic             sub_sync,
    input  logic [1:0]       pm,
    input  logic             wram_mode,
    input  logic             wram_for_sub,
    input  logic             sub_req,
    output logic             port_busy,
    output logic             asic_miss,
    wram_asic_port_if.master bus
);

    localparam int SIG_W = 1 + ADDR_W + 16;
    localparam int CNT_W = $clog2(SYNC_BUDGET + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t BUDGET    = cnt_t'(SYNC_BUDGET);
    localparam cnt_t BUDGET_M1 = cnt_t'(SYNC_BUDGET - 1);

    state_t           state;
    state_t           state_nxt;
    logic             enable;
    logic             strobe;
    logic             accept;
    logic             aborted;
    logic             abort_now;
    logic             abort_done;
    logic [SIG_W-1:0] sig;
    logic [SIG_W-1:0] last_sig;
    logic             sig_valid;
    logic             req_we;
    waddr_t           req_addr;
    logic [15:0]      req_din;
    logic [1:0]       req_pm;
    logic [15:0]      old_data;
    logic [15:0]      wr_data;
    logic [15:0]      merged;
    logic [15:0]      dout_q;
    cnt_t             sync_cnt;
    logic             miss_q;

    assign enable    = !wram_mode && wram_for_sub;
    assign strobe    = bus.asic_oe || bus.asic_we;
    assign sig       = {bus.asic_we, bus.asic_addr, bus.asic_din};
    assign accept    = sub_sync && (state == IDLE) && enable && !sub_req &&
                       strobe && (!sig_valid || (sig != last_sig));
    assign abort_now = aborted || !enable;
    assign abort_done = (state != IDLE) && (state_nxt == IDLE) && abort_now;

    assign bus.mem_addr  = req_addr;
    assign bus.mem_din   = wr_data;
    assign bus.asic_dout = dout_q;
    assign asic_miss     = miss_q;

    pm_nibble_merge u_merge (
        .old_data (old_data),
        .new_data (req_din),
        .pm       (req_pm),
        .merged   (merged)
    );

    // State register; reset drops any request on the next edge.
    always_ff @(posedge clk_asic) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and memory-side strobes decoded from the state.
    always_comb begin
        state_nxt   = state;
        bus.mem_req = 1'b0;
        bus.mem_we  = 1'b0;
        port_busy   = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (accept)
                    state_nxt = (!bus.asic_we || pm_active(pm)) ? RD : WR;
            end
            RD: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ack)
                    state_nxt = (req_we && !abort_now) ? MERGE : IDLE;
            end
            MERGE: begin
                state_nxt = abort_now ? IDLE : WR;
            end
            WR: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = 1'b1;
                if (bus.mem_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields, read-back data and merged write data.
    always_ff @(posedge clk_asic) begin
        if (rst) begin
            req_we   <= 1'b0;
            req_addr <= '0;
            req_din  <= '0;
            req_pm   <= PM_OFF;
            old_data <= '0;
            wr_data  <= '0;
            dout_q   <= '0;
        end else begin
            if (accept) begin
                req_we   <= bus.asic_we;
                req_addr <= bus.asic_addr;
                req_din  <= bus.asic_din;
                req_pm   <= pm;
                wr_data  <= bus.asic_din;
            end
            if (state == RD && bus.mem_ack && !abort_now) begin
                if (req_we) old_data <= bus.mem_dout;
                else        dout_q   <= bus.mem_dout;
            end
            if (state == MERGE) wr_data <= merged;
        end
    end

    // Signature of the last served strobe, for duplicate suppression.
    always_ff @(posedge clk_asic) begin
        if (rst) begin
            sig_valid <= 1'b0;
            last_sig  <= '0;
        end else if (accept) begin
            sig_valid <= 1'b1;
            last_sig  <= sig;
        end else if (!enable || (sub_sync && !strobe) || abort_done) begin
            sig_valid <= 1'b0;
        end
    end

    // Remember a mid-transaction loss of ownership until the cycle ends.
    always_ff @(posedge clk_asic) begin
        if (rst)                         aborted <= 1'b0;
        else if (state_nxt == IDLE)      aborted <= 1'b0;
        else if (port_busy && !enable)   aborted <= 1'b1;
    end

    // Count sub_sync ticks while busy; flag a miss when the budget is used.
    always_ff @(posedge clk_asic) begin
        if (rst) begin
            sync_cnt <= '0;
            miss_q   <= 1'b0;
        end else if (accept) begin
            sync_cnt <= '0;
            miss_q   <= 1'b0;
        end else if (port_busy && sub_sync && (sync_cnt != BUDGET)) begin
            sync_cnt <= sync_cnt + 1'b1;
            if (sync_cnt == BUDGET_M1) miss_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wram_asic_port.sv
// Self-checking bench for wram_asic_port.
// Memory responder pops expected transactions from a scoreboard queue.
module tb_wram_asic_port;
    import mcd_wram_pkg::*;

    typedef struct packed {
        logic        we;
        logic [16:0] addr;
        logic [15:0] data;
    } txn_t;

    logic       clk_asic = 1'b0;
    logic       rst;
    logic       sub_sync;
    logic [1:0] pm;
    logic       wram_mode;
    logic       wram_for_sub;
    logic       sub_req;
    logic       port_busy;
    logic       asic_miss;

    int n_vec   = 0;
    int n_err   = 0;
    int n_req   = 0;
    int ack_dly = 3;

    txn_t        exp_q[$];
    logic [15:0] mem [logic [16:0]];

    wram_asic_port_if bus ();

    wram_asic_port #(.SYNC_BUDGET(2)) dut (
        .clk_asic     (clk_asic),
        .rst          (rst),
        .sub_sync     (sub_sync),
        .pm           (pm),
        .wram_mode    (wram_mode),
        .wram_for_sub (wram_for_sub),
        .sub_req      (sub_req),
        .port_busy    (port_busy),
        .asic_miss    (asic_miss),
        .bus          (bus)
    );

    always #5 clk_asic = ~clk_asic;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mem_rd(input logic [16:0] a);
        return mem.exists(a) ? mem[a] : 16'h0000;
    endfunction

    task automatic sb_push(input logic w, input logic [16:0] a,
                           input logic [15:0] d);
        txn_t t;
        t.we   = w;
        t.addr = a;
        t.data = d;
        exp_q.push_back(t);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_asic);
    endtask

    task automatic wait_done(input int target);
        int k;
        k = 0;
        while (!(n_req >= target && port_busy === 1'b0 &&
                 bus.mem_ack === 1'b0) && k < 400) begin
            @(negedge clk_asic);
            k++;
        end
        check("done_in_time", 32'(k < 400), 1);
    endtask

    // sub_sync: one clk-wide tick every 10 clocks
    initial begin
        sub_sync = 1'b0;
        forever begin
            repeat (9) @(negedge clk_asic);
            sub_sync = 1'b1;
            @(negedge clk_asic);
            sub_sync = 1'b0;
        end
    end

    // memory responder and scoreboard consumer
    initial begin
        txn_t        t;
        logic        hw;
        logic [16:0] ha;
        logic [15:0] hd;
        bus.mem_ack  = 1'b0;
        bus.mem_dout = 16'h0000;
        forever begin
            @(negedge clk_asic);
            if (bus.mem_req === 1'b1) begin
                n_req++;
                check("sb_has_txn", 32'(exp_q.size() != 0), 1);
                hw = bus.mem_we;
                ha = bus.mem_addr;
                hd = bus.mem_din;
                if (exp_q.size() != 0) begin
                    t = exp_q.pop_front();
                    check("req_we", 32'(hw), 32'(t.we));
                    check("req_addr", 32'(ha), 32'(t.addr));
                    if (t.we) check("req_data", 32'(hd), 32'(t.data));
                end
                repeat (ack_dly) @(negedge clk_asic);
                check("req_held", 32'(bus.mem_req), 1);
                bus.mem_ack  = 1'b1;
                bus.mem_dout = hw ? 16'hDEAD : mem_rd(ha);
                if (hw) mem[ha] = hd;
                @(negedge clk_asic);
                bus.mem_ack  = 1'b0;
                bus.mem_dout = 16'h0000;
            end
        end
    end

    task automatic write_case(input string tag, input logic [1:0] p,
                              input logic [16:0] a, input logic [15:0] old,
                              input logic [15:0] din, input logic [15:0] want,
                              input bit rmw, input bit both);
        int n0;
        int nt;
        mem[a] = old;
        n0 = n_req;
        nt = rmw ? 2 : 1;
        if (rmw) sb_push(1'b0, a, 16'h0000);
        sb_push(1'b1, a, want);
        pm            = p;
        bus.asic_addr = a;
        bus.asic_din  = din;
        bus.asic_oe   = both;
        bus.asic_we   = 1'b1;
        wait_done(n0 + nt);
        cycles(30);
        check({tag, "_cnt"}, 32'(n_req - n0), 32'(nt));
        check({tag, "_mem"}, 32'(mem_rd(a)), 32'(want));
        bus.asic_we = 1'b0;
        bus.asic_oe = 1'b0;
        cycles(12);
    endtask

    initial begin
        int n0;
        int k;
        rst           = 1'b1;
        pm            = PM_OFF;
        wram_mode     = 1'b0;
        wram_for_sub  = 1'b1;
        sub_req       = 1'b0;
        bus.asic_oe   = 1'b0;
        bus.asic_we   = 1'b0;
        bus.asic_addr = '0;
        bus.asic_din  = '0;
        cycles(3);
        check("rst_req", 32'(bus.mem_req), 0);
        check("rst_busy", 32'(port_busy), 0);
        check("rst_miss", 32'(asic_miss), 0);
        check("rst_dout", 32'(bus.asic_dout), 0);
        rst = 1'b0;
        cycles(2);

        // plain read, strobe held: served once
        mem[17'h01000] = 16'hBEEF;
        sb_push(1'b0, 17'h01000, 16'h0000);
        n0 = n_req;
        bus.asic_addr = 17'h01000;
        bus.asic_oe   = 1'b1;
        wait_done(n0 + 1);
        check("rd_data", 32'(bus.asic_dout), 32'hBEEF);
        check("rd_nomiss", 32'(asic_miss), 0);
        cycles(30);
        check("rd_once", 32'(n_req - n0), 1);
        bus.asic_oe = 1'b0;
        cycles(12);

        write_case("wr_off",   2'b00, 17'h00040, 16'hFFFF, 16'h1234, 16'h1234, 0, 0);
        write_case("wr_under", 2'b01, 17'h00080, 16'h0F00, 16'h1234, 16'h1F34, 1, 0);
        write_case("wr_over",  2'b10, 17'h000C0, 16'hABCD, 16'h0500, 16'hA5CD, 1, 0);
        write_case("wr_pm11",  2'b11, 17'h00100, 16'h0F00, 16'h0034, 16'h0034, 0, 1);

        // 1M mode disables the port
        n0 = n_req;
        wram_mode     = 1'b1;
        bus.asic_addr = 17'h02000;
        bus.asic_oe   = 1'b1;
        cycles(30);
        check("mode1_noreq", 32'(n_req - n0), 0);
        check("mode1_idle", 32'(port_busy), 0);
        bus.asic_oe = 1'b0;
        wram_mode   = 1'b0;
        cycles(12);

        // abort an overwrite during its read phase, then reissue
        mem[17'h00300] = 16'h1111;
        ack_dly = 6;
        sb_push(1'b0, 17'h00300, 16'h0000);
        n0 = n_req;
        pm            = PM_OVER;
        bus.asic_addr = 17'h00300;
        bus.asic_din  = 16'h2200;
        bus.asic_we   = 1'b1;
        k = 0;
        while (bus.mem_req !== 1'b1 && k < 40) begin
            @(negedge clk_asic);
            k++;
        end
        check("abort_req_seen", 32'(bus.mem_req), 1);
        wram_for_sub = 1'b0;
        cycles(2);
        check("abort_req_held", 32'(bus.mem_req), 1);
        k = 0;
        while (port_busy !== 1'b0 && k < 40) begin
            @(negedge clk_asic);
            k++;
        end
        check("abort_idle", 32'(port_busy), 0);
        cycles(20);
        check("abort_no_wr", 32'(n_req - n0), 1);
        check("abort_mem", 32'(mem_rd(17'h00300)), 32'h1111);
        ack_dly = 3;
        sb_push(1'b0, 17'h00300, 16'h0000);
        sb_push(1'b1, 17'h00300, 16'h2211);
        wram_for_sub = 1'b1;
        wait_done(n0 + 3);
        check("reissue_mem", 32'(mem_rd(17'h00300)), 32'h2211);
        bus.asic_we = 1'b0;
        cycles(12);

        // slow memory overruns the sub_sync budget
        mem[17'h04000] = 16'h5A5A;
        ack_dly = 30;
        sb_push(1'b0, 17'h04000, 16'h0000);
        n0 = n_req;
        bus.asic_addr = 17'h04000;
        bus.asic_oe   = 1'b1;
        wait_done(n0 + 1);
        check("budget_miss", 32'(asic_miss), 1);
        check("budget_data", 32'(bus.asic_dout), 32'h5A5A);
        bus.asic_oe = 1'b0;
        ack_dly = 3;
        cycles(12);

        // sub_req blocks accept; next accept clears the miss
        mem[17'h05000] = 16'h7777;
        sub_req = 1'b1;
        sb_push(1'b0, 17'h05000, 16'h0000);
        n0 = n_req;
        bus.asic_addr = 17'h05000;
        bus.asic_oe   = 1'b1;
        cycles(30);
        check("subreq_block", 32'(n_req - n0), 0);
        check("miss_sticky", 32'(asic_miss), 1);
        sub_req = 1'b0;
        wait_done(n0 + 1);
        check("subreq_data", 32'(bus.asic_dout), 32'h7777);
        check("miss_cleared", 32'(asic_miss), 0);
        bus.asic_oe = 1'b0;
        cycles(12);

        check("sb_empty", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
